// File: rtl/ram_arbiter.sv
// Two-requester arbiter (video read-only, CPU read/write) for a single-port RAM with combinational read.
// Optional contention counter on cpuWaitCycles enabled by `define RAM_ARB_WAIT_COUNT_EN.
module ram_arbiter #(
    parameter int Bits = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            vidReq,
    input  logic [Bits-1:0] vidAddr,
    output logic            vidAck,
    output logic [7:0]      vidData,
    input  logic            cpuReq,
    input  logic            cpuWrite,
    input  logic [Bits-1:0] cpuAddr,
    input  logic [7:0]      cpuDataIn,
    output logic            cpuAck,
    output logic [7:0]      cpuData,
    output logic [15:0]     cpuWaitCycles,
    output logic            ramWriteEnabled,
    output logic [Bits-1:0] ramAddress,
    output logic [7:0]      ramDataIn,
    input  logic [7:0]      ramDataOut
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_VID = 2'd1,
        GNT_CPU = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            vid_elig, cpu_elig;
    logic [Bits-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]      ram_din_q, ram_din_d;
    logic            wr_q, wr_d;
    logic            vid_ack_q, vid_ack_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic [7:0]      vid_data_q, vid_data_d;
    logic [7:0]      cpu_data_q, cpu_data_d;

    // A requester is never eligible while it holds the grant, so a req still high in its
    // ack cycle is seen as a fresh request one edge later.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        vid_elig   = vidReq && (state_q != GNT_VID);
        cpu_elig   = cpuReq && (state_q != GNT_CPU);
        state_d    = IDLE;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        wr_d       = 1'b0;
        vid_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        vid_data_d = vid_data_q;
        cpu_data_d = cpu_data_q;

        if (vid_elig) begin
            state_d = GNT_VID;
        end else if (cpu_elig) begin
            state_d = GNT_CPU;
        end

        case (state_d)
            GNT_VID: ram_addr_d = vidAddr;
            GNT_CPU: begin
                ram_addr_d = cpuAddr;
                ram_din_d  = cpuDataIn;
                wr_d       = cpuWrite;
            end
            default: ;
        endcase

        // The grant cycle's combinational read is captured at its closing edge.
        case (state_q)
            GNT_VID: begin
                vid_data_d = ramDataOut;
                vid_ack_d  = 1'b1;
            end
            GNT_CPU: begin
                cpu_data_d = ramDataOut;
                cpu_ack_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            wr_q       <= 1'b0;
            vid_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            vid_data_q <= '0;
            cpu_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            wr_q       <= wr_d;
            vid_ack_q  <= vid_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_data_q <= vid_data_d;
            cpu_data_q <= cpu_data_d;
        end
    end

`ifdef RAM_ARB_WAIT_COUNT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Counts edges where the CPU wanted the RAM but lost to video; saturates.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (cpu_elig && (state_d == GNT_VID) && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign cpuWaitCycles = wait_cnt_q;
`else
    assign cpuWaitCycles = 16'h0000;
`endif

    // Gating with reset keeps a write from committing at a reset edge mid-grant.
    assign ramWriteEnabled = wr_q & ~reset;
    assign ramAddress      = ram_addr_q;
    assign ramDataIn       = ram_din_q;
    assign vidAck          = vid_ack_q;
    assign cpuAck          = cpu_ack_q;
    assign vidData         = vid_data_q;
    assign cpuData         = cpu_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 64KB RAM preloaded with known bytes.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        vidReq;
    logic [15:0] vidAddr;
    logic        vidAck;
    logic [7:0]  vidData;
    logic        cpuReq;
    logic        cpuWrite;
    logic [15:0] cpuAddr;
    logic [7:0]  cpuDataIn;
    logic        cpuAck;
    logic [7:0]  cpuData;
    logic [15:0] cpuWaitCycles;
    logic        ramWriteEnabled;
    logic [15:0] ramAddress;
    logic [7:0]  ramDataIn;
    logic [7:0]  ramDataOut;

    int checks = 0;
    int errors = 0;

`ifdef RAM_ARB_WAIT_COUNT_EN
    localparam logic [15:0] CONTENTION_WAITS = 16'd1;
`else
    localparam logic [15:0] CONTENTION_WAITS = 16'd0;
`endif

    ram_arbiter #(.Bits(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .vidReq         (vidReq),
        .vidAddr        (vidAddr),
        .vidAck         (vidAck),
        .vidData        (vidData),
        .cpuReq         (cpuReq),
        .cpuWrite       (cpuWrite),
        .cpuAddr        (cpuAddr),
        .cpuDataIn      (cpuDataIn),
        .cpuAck         (cpuAck),
        .cpuData        (cpuData),
        .cpuWaitCycles  (cpuWaitCycles),
        .ramWriteEnabled(ramWriteEnabled),
        .ramAddress     (ramAddress),
        .ramDataIn      (ramDataIn),
        .ramDataOut     (ramDataOut)
    );

    logic [7:0] mem [0:65535];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0003] = 8'h81;
        mem[16'h0005] = 8'h42;
        mem[16'h2000] = 8'h0E;
        mem[16'h2004] = 8'hE6;
        mem[16'h2010] = 8'h08;
    end

    always @(posedge clk) begin
        if (ramWriteEnabled) mem[ramAddress] <= ramDataIn;
    end

    assign ramDataOut = mem[ramAddress];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        vidReq    = 1'b1;
        vidAddr   = 16'h0003;
        cpuReq    = 1'b1;
        cpuWrite  = 1'b1;
        cpuAddr   = 16'h2000;
        cpuDataIn = 8'hA5;

        // Reset held with both requests active
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_vid_ack", vidAck, 0);
            check("rst_cpu_ack", cpuAck, 0);
            check("rst_ram_we", ramWriteEnabled, 0);
            check("rst_ram_addr", ramAddress, 0);
            check("rst_ram_din", ramDataIn, 0);
            check("rst_vid_data", vidData, 0);
            check("rst_cpu_data", cpuData, 0);
            check("rst_wait", cpuWaitCycles, 0);
        end
        reset  = 1'b0;
        vidReq = 1'b0;
        cpuReq = 1'b0;
        step();
        check("idle_cpu_ack", cpuAck, 0);
        check("idle_we", ramWriteEnabled, 0);

        // CPU write then back-to-back read of the same address
        cpuReq = 1'b1; cpuWrite = 1'b1; cpuAddr = 16'h2000; cpuDataIn = 8'hA5;
        step();
        check("wr_grant_ack", cpuAck, 0);
        check("wr_grant_we", ramWriteEnabled, 1);
        check("wr_grant_addr", ramAddress, 16'h2000);
        check("wr_grant_din", ramDataIn, 8'hA5);
        step();
        check("wr_ack", cpuAck, 1);
        check("wr_old_data", cpuData, 8'h0E);
        check("wr_ack_we", ramWriteEnabled, 0);
        cpuWrite = 1'b0;
        step();
        check("rd_grant_ack", cpuAck, 0);
        check("rd_grant_we", ramWriteEnabled, 0);
        step();
        check("rd_ack", cpuAck, 1);
        check("rd_data", cpuData, 8'hA5);
        cpuReq = 1'b0;
        step();
        check("rd_no_second_ack", cpuAck, 0);
        check("rd_data_held", cpuData, 8'hA5);

        // Video reads; ramDataIn must hold the last CPU value
        vidReq = 1'b1; vidAddr = 16'h0003;
        step();
        check("v1_grant_ack", vidAck, 0);
        check("v1_grant_addr", ramAddress, 16'h0003);
        check("v1_din_hold", ramDataIn, 8'hA5);
        check("v1_grant_we", ramWriteEnabled, 0);
        step();
        check("v1_ack", vidAck, 1);
        check("v1_data", vidData, 8'h81);
        vidAddr = 16'h2004;
        step();
        check("v2_grant_ack", vidAck, 0);
        step();
        check("v2_ack", vidAck, 1);
        check("v2_data", vidData, 8'hE6);
        vidReq = 1'b0;
        step();
        check("v2_no_second_ack", vidAck, 0);

        // Both requesters held: V, C, V, C
        vidReq = 1'b1; vidAddr = 16'h0003;
        cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 16'h0005;
        step();
        check("c1_addr_v", ramAddress, 16'h0003);
        check("c1_acks", {vidAck, cpuAck}, 2'b00);
        step();
        check("c2_addr_c", ramAddress, 16'h0005);
        check("c2_acks", {vidAck, cpuAck}, 2'b10);
        check("c2_vid_data", vidData, 8'h81);
        step();
        check("c3_addr_v", ramAddress, 16'h0003);
        check("c3_acks", {vidAck, cpuAck}, 2'b01);
        check("c3_cpu_data", cpuData, 8'h42);
        step();
        check("c4_addr_c", ramAddress, 16'h0005);
        check("c4_acks", {vidAck, cpuAck}, 2'b10);
        vidReq = 1'b0;
        step();
        check("c5_acks", {vidAck, cpuAck}, 2'b01);
        check("c5_cpu_data", cpuData, 8'h42);
        cpuReq = 1'b0;
        step();
        check("c6_acks", {vidAck, cpuAck}, 2'b00);
        check("c6_wait", cpuWaitCycles, CONTENTION_WAITS);

        // Reset during a CPU write grant drops the access
        cpuReq = 1'b1; cpuWrite = 1'b1; cpuAddr = 16'h2010; cpuDataIn = 8'h55;
        step();
        check("mr_grant_we", ramWriteEnabled, 1);
        reset = 1'b1;
        #1;
        check("mr_we_gated", ramWriteEnabled, 0);
        step();
        check("mr_no_ack", cpuAck, 0);
        check("mr_addr_clr", ramAddress, 0);
        check("mr_cpu_data_clr", cpuData, 0);
        check("mr_vid_data_clr", vidData, 0);
        check("mr_wait_clr", cpuWaitCycles, 0);
        reset = 1'b0; cpuWrite = 1'b0;
        step();
        check("mr_rd_grant_ack", cpuAck, 0);
        step();
        check("mr_rd_ack", cpuAck, 1);
        check("mr_rd_unchanged", cpuData, 8'h08);
        cpuReq = 1'b0;
        step();
        check("mr_end_ack", cpuAck, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
